// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_W       = 32;
    localparam int unsigned DIV_ITERS   = 32;
    localparam int unsigned DIV_LATENCY = 34;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider with two AXI-Stream operand inputs and a result pulse.
// Build option: define DIV_ZERO_FAST_EN to short-circuit divide-by-zero straight to the result.
module seq_divider
    import div_pkg::*;
#(
    parameter bit          SIGNED = 1'b1,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_axis_dividend_tvalid,
    output logic                  s_axis_dividend_tready,
    input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
    input  logic                  s_axis_divisor_tvalid,
    output logic                  s_axis_divisor_tready,
    input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
    output logic                  m_axis_dout_tvalid,
    output logic [2*DATA_W-1:0]   m_axis_dout_tdata
);

    localparam int unsigned ITER_W = $clog2(DIV_ITERS);
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    div_state_e        state;
    logic              dvd_cap, dvs_cap;
    logic [DIV_W-1:0]  dvd_q, dvs_q;
    logic [DIV_W:0]    rem_q;
    logic [DIV_W-1:0]  quo_q;
    logic [DIV_W-1:0]  dvs_mag_q;
    logic              neg_quo_q, neg_rem_q;
    logic [ITER_W-1:0] iter_q;

    logic              take_dvd, take_dvs, have_dvd, have_dvs;
    logic [DIV_W-1:0]  dvd_sel, dvs_sel, dvd_mag, dvs_mag;
    logic              sgn_dvd, sgn_dvs;
    logic [DIV_W-1:0]  quo_fin, rem_fin;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*DIV_W:0] div_step(
        input logic [DIV_W:0]   rem,
        input logic [DIV_W-1:0] quo,
        input logic [DIV_W-1:0] dvs
    );
        logic [DIV_W+1:0] shifted;
        logic [DIV_W+1:0] diff;
        shifted = {rem, quo[DIV_W-1]};
        diff    = shifted - {2'b00, dvs};
        if (diff[DIV_W+1])
            return {shifted[DIV_W:0], quo[DIV_W-2:0], 1'b0};
        else
            return {diff[DIV_W:0], quo[DIV_W-2:0], 1'b1};
    endfunction

    // Operands as seen on the IDLE->CALC edge, including a same-cycle capture.
    always_comb begin
        take_dvd = s_axis_dividend_tvalid & s_axis_dividend_tready;
        take_dvs = s_axis_divisor_tvalid  & s_axis_divisor_tready;
        have_dvd = dvd_cap | take_dvd;
        have_dvs = dvs_cap | take_dvs;
        dvd_sel  = take_dvd ? s_axis_dividend_tdata : dvd_q;
        dvs_sel  = take_dvs ? s_axis_divisor_tdata  : dvs_q;
        sgn_dvd  = SIGNED & dvd_sel[DIV_W-1];
        sgn_dvs  = SIGNED & dvs_sel[DIV_W-1];
        dvd_mag  = sgn_dvd ? -dvd_sel : dvd_sel;
        dvs_mag  = sgn_dvs ? -dvs_sel : dvs_sel;
        quo_fin  = neg_quo_q ? -quo_q : quo_q;
        rem_fin  = neg_rem_q ? -rem_q[DIV_W-1:0] : rem_q[DIV_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                  <= ST_IDLE;
            dvd_cap                <= 1'b0;
            dvs_cap                <= 1'b0;
            dvd_q                  <= '0;
            dvs_q                  <= '0;
            rem_q                  <= '0;
            quo_q                  <= '0;
            dvs_mag_q              <= '0;
            neg_quo_q              <= 1'b0;
            neg_rem_q              <= 1'b0;
            iter_q                 <= '0;
            s_axis_dividend_tready <= 1'b1;
            s_axis_divisor_tready  <= 1'b1;
            m_axis_dout_tvalid     <= 1'b0;
            m_axis_dout_tdata      <= '0;
        end else begin
            m_axis_dout_tvalid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (take_dvd) dvd_q <= s_axis_dividend_tdata;
                    if (take_dvs) dvs_q <= s_axis_divisor_tdata;
                    dvd_cap                <= have_dvd;
                    dvs_cap                <= have_dvs;
                    s_axis_dividend_tready <= !have_dvd;
                    s_axis_divisor_tready  <= !have_dvs;
                    if (have_dvd && have_dvs) begin
                        if (FAST_ZERO && dvs_sel == '0) begin
                            state              <= ST_DONE;
                            m_axis_dout_tvalid <= 1'b1;
                            m_axis_dout_tdata  <= {{DIV_W{1'b1}}, dvd_sel};
                        end else begin
                            state     <= ST_CALC;
                            rem_q     <= '0;
                            quo_q     <= dvd_mag;
                            dvs_mag_q <= dvs_mag;
                            neg_quo_q <= sgn_dvd ^ sgn_dvs;
                            neg_rem_q <= sgn_dvd;
                            iter_q    <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_mag_q);
                    iter_q         <= iter_q + ITER_W'(1);
                    if (iter_q == ITER_W'(DIV_ITERS - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    state              <= ST_DONE;
                    m_axis_dout_tvalid <= 1'b1;
                    m_axis_dout_tdata  <= {quo_fin, rem_fin};
                end
                ST_DONE: begin
                    state                  <= ST_IDLE;
                    dvd_cap                <= 1'b0;
                    dvs_cap                <= 1'b0;
                    s_axis_dividend_tready <= 1'b1;
                    s_axis_divisor_tready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: unsigned and signed dividers share stimulus and are checked against an arithmetic model.
module tb_seq_divider;
    import div_pkg::*;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        dvd_valid, dvs_valid;
    logic [31:0] dvd_data, dvs_data;
    logic        u_dvd_rdy, u_dvs_rdy, u_valid;
    logic        s_dvd_rdy, s_dvs_rdy, s_valid;
    logic [63:0] u_data, s_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.SIGNED(1'b0), .DATA_W(32)) dut_u (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(u_dvd_rdy),
        .s_axis_dividend_tdata(dvd_data),
        .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(u_dvs_rdy),
        .s_axis_divisor_tdata(dvs_data),
        .m_axis_dout_tvalid(u_valid), .m_axis_dout_tdata(u_data)
    );

    seq_divider #(.SIGNED(1'b1), .DATA_W(32)) dut_s (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(s_dvd_rdy),
        .s_axis_dividend_tdata(dvd_data),
        .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(s_dvs_rdy),
        .s_axis_divisor_tdata(dvs_data),
        .m_axis_dout_tvalid(s_valid), .m_axis_dout_tdata(s_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result straight from integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int          sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return {q, r};
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int gap, input string tag);
        int          exp_lat, lat_u, lat_s, n_u, n_s;
        logic [63:0] d_u, d_s;
        logic [1:0]  rdy_u, rdy_s;
        exp_lat = (FAST && b == 32'd0) ? 1 : int'(DIV_LATENCY);
        lat_u = 0; lat_s = 0; n_u = 0; n_s = 0;
        d_u = '0; d_s = '0; rdy_u = '0; rdy_s = '0;
        @(negedge clk);
        chk({tag, ".rdy_idle"}, {60'd0, u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy}, 64'hF);
        dvd_valid = 1'b1; dvd_data = a;
        if (gap == 0) begin dvs_valid = 1'b1; dvs_data = b; end
        for (int c = 1; c <= gap; c++) begin
            @(negedge clk);
            dvd_data = $urandom;
            chk({tag, ".rdy_stagger"}, {60'd0, u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy}, 64'h5);
            if (c == gap) begin dvs_valid = 1'b1; dvs_data = b; end
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (exp_lat > 1 && k >= 2 && k <= 30) begin
                dvd_valid = 1'($urandom); dvd_data = $urandom;
                dvs_valid = 1'($urandom); dvs_data = $urandom;
            end else begin
                dvd_valid = 1'b0; dvs_valid = 1'b0;
            end
            if (u_valid) begin n_u++; if (lat_u == 0) begin lat_u = k; d_u = u_data; end end
            if (s_valid) begin n_s++; if (lat_s == 0) begin lat_s = k; d_s = s_data; end end
            if (k == exp_lat + 1) begin
                rdy_u = {u_dvd_rdy, u_dvs_rdy};
                rdy_s = {s_dvd_rdy, s_dvs_rdy};
            end
        end
        chk({tag, ".u_lat"}, 64'(lat_u), 64'(exp_lat));
        chk({tag, ".s_lat"}, 64'(lat_s), 64'(exp_lat));
        chk({tag, ".u_pulses"}, 64'(n_u), 64'd1);
        chk({tag, ".s_pulses"}, 64'(n_s), 64'd1);
        chk({tag, ".u_rdy_after"}, 64'(rdy_u), 64'h3);
        chk({tag, ".s_rdy_after"}, 64'(rdy_s), 64'h3);
        if (b != 32'd0 || FAST) begin
            chk({tag, ".u_data"}, d_u, ref_div(a, b, 1'b0));
            chk({tag, ".s_data"}, d_s, ref_div(a, b, 1'b1));
            chk({tag, ".u_hold"}, u_data, ref_div(a, b, 1'b0));
            chk({tag, ".s_hold"}, s_data, ref_div(a, b, 1'b1));
        end
    endtask

    initial begin
        int          pulses;
        logic [31:0] ra, rb;
        resetn = 1'b0; dvd_valid = 1'b0; dvs_valid = 1'b0; dvd_data = '0; dvs_data = '0;
        repeat (3) @(negedge clk);
        chk("rst.valid", {62'd0, u_valid, s_valid}, 64'd0);
        chk("rst.u_data", u_data, 64'd0);
        chk("rst.s_data", s_data, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst.rdy", {60'd0, u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy}, 64'hF);

        do_div(32'd100, 32'd7, 0, "u100_7");
        chk("u100_7.literal", u_data, 64'h0000000E_00000002);
        do_div(32'hFFFF_FFF9, 32'd2, 0, "m7_2");
        chk("m7_2.literal", s_data, 64'hFFFFFFFD_FFFFFFFF);
        do_div(32'd7, 32'hFFFF_FFFE, 1, "7_m2");
        chk("7_m2.literal", s_data, 64'hFFFFFFFD_00000001);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 2, "min_m1");
        chk("min_m1.literal", s_data, 64'h80000000_00000000);
        do_div(32'd50, 32'd5, 3, "stag50_5");
        chk("stag50_5.literal", u_data, 64'h0000000A_00000000);
        do_div(32'd123, 32'd0, 0, "zero");
        do_div(32'hFFFF_FFFF, 32'd1, 0, "max_1");
        do_div(32'd0, 32'd5, 2, "zero_dvd");

        // Abort in the tenth CALC cycle.
        @(negedge clk);
        dvd_valid = 1'b1; dvd_data = 32'd1000; dvs_valid = 1'b1; dvs_data = 32'd3;
        @(negedge clk);
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort.valid", {62'd0, u_valid, s_valid}, 64'd0);
        chk("abort.u_data", u_data, 64'd0);
        chk("abort.s_data", s_data, 64'd0);
        chk("abort.rdy", {60'd0, u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy}, 64'hF);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (u_valid) pulses++;
            if (s_valid) pulses++;
        end
        chk("abort.no_pulse", 64'(pulses), 64'd0);
        do_div(32'd9, 32'd3, 0, "post_abort");
        chk("post_abort.literal", s_data, 64'h00000003_00000000);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (i % 5 == 0) ra = ra >> $urandom_range(1, 31);
            do_div(ra, rb, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter SIGNED, default 1, selects two's-complement division (1) or unsigned division (0).
REQ-002 Parameter DATA_W, default 32, sets the operand width; only 32 is supported.
REQ-003 Clock is `clk`, input, 1 bit; the single clock, rising edge.
REQ-004 Reset is `resetn`, input, 1 bit; synchronous, active-low.
REQ-005 `s_axis_dividend_tvalid`, input, 1 bit: dividend offered.
REQ-006 `s_axis_dividend_tready`, output, 1 bit: dividend can be accepted.
REQ-007 `s_axis_dividend_tdata`, input, 32 bits: dividend.
REQ-008 `s_axis_divisor_tvalid`, input, 1 bit: divisor offered.
REQ-009 `s_axis_divisor_tready`, output, 1 bit: divisor can be accepted.
REQ-010 `s_axis_divisor_tdata`, input, 32 bits: divisor.
REQ-011 `m_axis_dout_tvalid`, output, 1 bit: one-cycle result pulse.
REQ-012 `m_axis_dout_tdata`, output, 64 bits: {quotient[63:32], remainder[31:0]}.

Function
REQ-013 Each input channel SHALL capture its data independently on the cycle where its tvalid and tready are both 1.
REQ-014 Handshake rules for each channel's tready:
- high in IDLE while that channel is not yet captured;
- low once that channel is captured;
- low in CALC, FIX and DONE.
REQ-015 States SHALL be IDLE, CALC, FIX and DONE, with these transitions:
- IDLE->CALC on the edge where both operands are held (same-cycle or staggered capture);
- CALC->FIX after 32 iterations;
- FIX->DONE;
- DONE->IDLE.
REQ-016 Cycle timing is fixed, measured from the cycle in which the last operand handshakes (cycle 0):
- CALC occupies cycles 1-32;
- FIX occupies cycle 33;
- DONE occupies cycle 34, with m_axis_dout_tvalid=1;
- IDLE with both treadys high at cycle 35.
REQ-017 CALC SHALL perform one restoring radix-2 step per cycle on the 32-bit magnitudes, with the partial remainder held 33 bits wide.
REQ-018 With SIGNED=1:
- magnitudes are taken at the transition into CALC;
- in FIX the quotient is negated when the operand signs differ;
- in FIX the remainder takes the sign of the dividend;
- the quotient truncates toward zero.
REQ-019 With SIGNED=1, 0x80000000/0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-020 m_axis_dout_tdata SHALL update on entry to DONE and hold its value until the next DONE.
REQ-021 m_axis_dout_tvalid SHALL be exactly one cycle wide; there is no output backpressure.
REQ-022 While in CALC, FIX or DONE, offered tvalids SHALL be ignored (tready is 0).

Reset
REQ-023 While resetn=0 at a clock edge, at that edge the block SHALL:
- enter IDLE;
- clear both captured flags;
- clear the iteration counter;
- set m_axis_dout_tvalid=0 and m_axis_dout_tdata=0.
REQ-024 A reset during CALC or FIX SHALL abort the operation with no result pulse.
REQ-025 Both treadys SHALL be 1 in the first cycle after resetn returns to 1.

Configuration
REQ-026 The macro is DIV_ZERO_FAST_EN.
- Defined: a divisor of 0 goes IDLE->DONE directly, so m_axis_dout_tvalid asserts at cycle 1 with tdata={0xFFFFFFFF, dividend} for both SIGNED values.
- Undefined: a divisor of 0 takes the full 34-cycle path, and the result value is unspecified but deterministic.

Structure
REQ-027 Package div_pkg SHALL hold:
- the state enum;
- DIV_W=32;
- DIV_ITERS=32;
- DIV_LATENCY=34.
REQ-028 The block SHALL be a single module with no sub-modules; the restoring step is an inline function.

Verification
REQ-029 Unsigned (SIGNED=0), 100/7 with both operands in the same cycle -> at cycle 34, tvalid=1 and tdata=0x0000000E_00000002.
REQ-030 SIGNED=1, -7/2 (0xFFFFFFF9/0x00000002) -> tdata=0xFFFFFFFD_FFFFFFFF; then 7/-2 -> tdata=0xFFFFFFFD_00000001.
REQ-031 SIGNED=1, 0x80000000/0xFFFFFFFF -> tdata=0x80000000_00000000.
REQ-032 Staggered operands: dividend 50 at cycle 0 (dividend tready drops), divisor 5 at cycle 3 -> tvalid at cycle 37 with tdata=0x0000000A_00000000; both treadys high at cycle 38.
REQ-033 resetn=0 in CALC cycle 10 -> no tvalid pulse, tdata=0, both treadys high in the first cycle after release; a following 9/3 -> tdata=0x00000003_00000000 at latency 34.
REQ-034 With DIV_ZERO_FAST_EN defined, 123/0 -> tvalid at cycle 1 with tdata=0xFFFFFFFF_0000007B; with it undefined -> tvalid at cycle 34.
